ssd1306_cmd_decoder: RTL and testbench
======================================

Name: ssd1306_cmd_decoder

Overview:
Front end for the framebuffer write side of the SSD1306-compatible VGA display. Oversamples the host's SPI-style pins (SCLK, MOSI, CS, DC) on CLK25MHz and assembles bytes MSB-first. Interprets the SSD1306 addressing command subset and converts data bytes into addressed framebuffer writes. Also exports display-on and inverse flags to the VGA scan-out.

Parameters:
SYNC_STAGES, 2, synchronizer flops per input pin before edge detect (min 2)
COLS, 128, framebuffer columns (col pointer 7 bits)
PAGES, 8, framebuffer pages of 8 rows (page pointer 3 bits)

Ports:
CLK25MHz  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
spi_sclk  in  1  host serial clock, async; data sampled on rising edge
spi_mosi  in  1  host serial data, async
spi_cs_n  in  1  host chip select, async, active-low
spi_dc  in  1  host data/command select: 0 command, 1 data
fb_we  out  1  framebuffer write strobe, one-cycle pulse
fb_addr  out  10  byte address = page*128 + col
fb_data  out  8  data byte; bit0 = top row of page
display_on  out  1  1 after 0xAF, 0 after 0xAE
invert  out  1  1 after 0xA7, 0 after 0xA6

Behaviour:
- Reset (async assert, sync release): fb_we=0, fb_addr=0, fb_data=0, display_on=0, invert=0; mode=PAGE(2), col=0, page=0, col_start=0, col_end=127, page_start=0, page_end=7, bit counter=0, FSM=IDLE. Reset mid-byte or mid-command discards all partial state.
- Inputs pass SYNC_STAGES flops plus one edge-detect flop; rising sclk edge is counted only while synchronized cs_n=0. Host SCLK is at most CLK25MHz/4.
- cs_n high clears the bit counter (partial byte dropped); FSM state and pointers are retained.
- Byte complete on 8th counted edge; DC is sampled with that edge. fb_we rises on the next CLK cycle, for exactly 1 cycle, with fb_addr/fb_data valid in the same cycle. fb_addr/fb_data hold until the next write.
- Command FSM (DC=0 bytes): IDLE, ARG1, ARG2, SKIP1.
  IDLE:
  - 0x20 -> ARG1 (mode); arg[1:0]: 0 horizontal, 1 vertical, 2 page, 3 ignored.
  - 0x21 -> ARG1/ARG2 (col_start, col_end = arg[6:0]); on ARG2, col <= col_start.
  - 0x22 -> ARG1/ARG2 (page_start, page_end = arg[2:0]); on ARG2, page <= page_start.
  - 0xB0-0xB7 -> page <= byte[2:0].
  - 0x00-0x0F -> col[3:0] <= byte[3:0].
  - 0x10-0x17 -> col[6:4] <= byte[2:0].
  - 0xAE/0xAF -> display_on. 0xA6/0xA7 -> invert.
  - 0x81, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB, 0x8D -> SKIP1; the next command byte is discarded.
  - All other opcodes: ignored, stay IDLE.
  - In ARG1/ARG2/SKIP1, any DC=0 byte is consumed as the argument regardless of value.
  - A DC=1 byte arriving in ARG1/ARG2/SKIP1 aborts the command (FSM -> IDLE, no register update) and is processed as data.
- Data byte (DC=1): write at the current pointer, then advance the pointer in the same cycle fb_we is high.
  - Horizontal: if col==col_end, col<=col_start and page advances (page==page_end -> page_start, else page+1); else col+1.
  - Vertical: if page==page_end, page<=page_start and col advances (col==col_end -> col_start, else col+1); else page+1.
  - Page: col+1 with 127 -> 0; page unchanged.
- Window with start>end: the pointer increments modulo 128/8 until it equals end. No error is flagged.

Test Plan:
- Reset, then in page mode send cmd 0xB3, 0x05, 0x12, then data 0xA5 -> fb_we one pulse, fb_addr=3*128+0x25=421, fb_data=0xA5; next data byte -> fb_addr=422.
- Send cmds 0x20,0x00, 0x21,0x7E,0x7F, 0x22,0x06,0x07, then 5 data bytes -> addresses 894, 895, 1022, 1023, 894.
- Send cmds 0x20,0x01, 0x21,0x00,0x01, 0x22,0x00,0x01, then 5 data bytes -> addresses 0, 128, 1, 129, 0.
- Send 0xAF, 0xA7, 0x81,0xAE -> display_on=1, invert=1 (the 0xAE is consumed as contrast arg); then send 0xAE -> display_on=0.
- Raise cs_n after 5 bits of a data byte, then send a full 0x3C -> exactly one fb_we with fb_data=0x3C at the expected address.
- Send 0x21,0x10, then a data byte 0xFF -> col_start/col_end unchanged, write lands at the pre-command pointer; assert reset_n=0 mid-byte -> fb_we=0 and all outputs zero immediately.

Source files
------------

// File: rtl/ssd1306_cmd_decoder.sv
// SSD1306 serial front end: pin sync, byte assembly, command decode
// and addressed framebuffer writes for the VGA scan-out.
module ssd1306_cmd_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = 128,
  parameter int PAGES       = 8
) (
  input  logic       CLK25MHz,
  input  logic       reset_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  input  logic       spi_dc,
  output logic       fb_we,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_data,
  output logic       display_on,
  output logic       invert
);

  localparam logic [6:0] COL_MAX  = 7'(COLS - 1);
  localparam logic [2:0] PAGE_MAX = 3'(PAGES - 1);

  localparam logic [1:0] M_HORZ = 2'd0;
  localparam logic [1:0] M_VERT = 2'd1;
  localparam logic [1:0] M_PAGE = 2'd2;

  localparam logic [1:0] C_MODE = 2'd0;
  localparam logic [1:0] C_COL  = 2'd1;
  localparam logic [1:0] C_PG   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE, S_ARG1, S_ARG2, S_SKIP1
  } state_t;

  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  // Async assert, release lined up with the clock.
  always_ff @(posedge CLK25MHz or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync, r_dc_sync;
  logic                   r_sclk_d;
  logic                   w_sclk_s, w_mosi_s, w_cs_s, w_dc_s;
  logic                   w_rise, w_done;
  logic [2:0]             r_cnt;
  logic [6:0]             r_shift;
  logic [7:0]             w_byte;

  always_ff @(posedge CLK25MHz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_dc_sync   <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0], spi_dc};
      r_sclk_d    <= w_sclk_s;
    end
  end

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_dc_s   = r_dc_sync[SYNC_STAGES-1];
  assign w_rise   = w_sclk_s & ~r_sclk_d & ~w_cs_s;
  assign w_done   = w_rise & (r_cnt == 3'd7);
  assign w_byte   = {r_shift, w_mosi_s};

  always_ff @(posedge CLK25MHz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt   <= 3'd0;
      r_shift <= 7'd0;
    end else if (w_cs_s) begin
      r_cnt   <= 3'd0;
    end else if (w_rise) begin
      r_cnt   <= r_cnt + 3'd1;
      r_shift <= w_byte[6:0];
    end
  end

  state_t     r_state, w_state_nxt;
  logic [1:0] r_cmd, w_cmd_nxt, r_mode, w_mode_nxt;
  logic [6:0] r_arg, w_arg_nxt;
  logic [6:0] r_col, w_col_nxt, r_cs, w_cs_nxt, r_ce, w_ce_nxt;
  logic [2:0] r_page, w_page_nxt, r_ps, w_ps_nxt, r_pe, w_pe_nxt;
  logic       r_we, w_we_nxt, r_disp, w_disp_nxt, r_inv, w_inv_nxt;
  logic [9:0] r_addr, w_addr_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic [6:0] w_col_adv;
  logic [2:0] w_page_adv;
  logic       w_skip;

  assign w_col_adv  = (r_col == r_ce) ? r_cs : r_col + 7'd1;
  assign w_page_adv = (r_page == r_pe) ? r_ps : r_page + 3'd1;
  assign w_skip     = w_byte inside {8'h81, 8'hA8, 8'hD3, 8'hD5,
                                     8'hD9, 8'hDA, 8'hDB, 8'h8D};

  always_ff @(posedge CLK25MHz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_cmd   <= C_MODE;
      r_mode  <= M_PAGE;
      r_arg   <= 7'd0;
      r_col   <= 7'd0;
      r_cs    <= 7'd0;
      r_ce    <= COL_MAX;
      r_page  <= 3'd0;
      r_ps    <= 3'd0;
      r_pe    <= PAGE_MAX;
      r_we    <= 1'b0;
      r_disp  <= 1'b0;
      r_inv   <= 1'b0;
      r_addr  <= 10'd0;
      r_data  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
      r_mode  <= w_mode_nxt;
      r_arg   <= w_arg_nxt;
      r_col   <= w_col_nxt;
      r_cs    <= w_cs_nxt;
      r_ce    <= w_ce_nxt;
      r_page  <= w_page_nxt;
      r_ps    <= w_ps_nxt;
      r_pe    <= w_pe_nxt;
      r_we    <= w_we_nxt;
      r_disp  <= w_disp_nxt;
      r_inv   <= w_inv_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_mode_nxt  = r_mode;
    w_arg_nxt   = r_arg;
    w_col_nxt   = r_col;
    w_cs_nxt    = r_cs;
    w_ce_nxt    = r_ce;
    w_page_nxt  = r_page;
    w_ps_nxt    = r_ps;
    w_pe_nxt    = r_pe;
    w_we_nxt    = 1'b0;
    w_disp_nxt  = r_disp;
    w_inv_nxt   = r_inv;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    if (w_done && w_dc_s) begin
      // Data aborts any pending command argument.
      w_state_nxt = S_IDLE;
      w_we_nxt    = 1'b1;
      w_addr_nxt  = {r_page, r_col};
      w_data_nxt  = w_byte;
      unique case (r_mode)
        M_HORZ: begin
          w_col_nxt = w_col_adv;
          if (r_col == r_ce) w_page_nxt = w_page_adv;
        end
        M_VERT: begin
          w_page_nxt = w_page_adv;
          if (r_page == r_pe) w_col_nxt = w_col_adv;
        end
        default: w_col_nxt = (r_col == COL_MAX) ? 7'd0 : r_col + 7'd1;
      endcase
    end else if (w_done) begin
      unique case (r_state)
        S_IDLE: begin
          unique case (1'b1)
            (w_byte == 8'h20): begin
              w_cmd_nxt = C_MODE; w_state_nxt = S_ARG1;
            end
            (w_byte == 8'h21): begin
              w_cmd_nxt = C_COL; w_state_nxt = S_ARG1;
            end
            (w_byte == 8'h22): begin
              w_cmd_nxt = C_PG; w_state_nxt = S_ARG1;
            end
            (w_byte[7:3] == 5'h16): w_page_nxt = w_byte[2:0];
            (w_byte[7:4] == 4'h0):  w_col_nxt = {r_col[6:4], w_byte[3:0]};
            (w_byte[7:3] == 5'h02): w_col_nxt = {w_byte[2:0], r_col[3:0]};
            (w_byte[7:1] == 7'h57): w_disp_nxt = w_byte[0];
            (w_byte[7:1] == 7'h53): w_inv_nxt = w_byte[0];
            w_skip:                 w_state_nxt = S_SKIP1;
            default: ;
          endcase
        end
        S_ARG1: begin
          w_arg_nxt   = w_byte[6:0];
          w_state_nxt = (r_cmd == C_MODE) ? S_IDLE : S_ARG2;
          if (r_cmd == C_MODE && w_byte[1:0] != 2'd3)
            w_mode_nxt = w_byte[1:0];
        end
        S_ARG2: begin
          w_state_nxt = S_IDLE;
          if (r_cmd == C_COL) begin
            w_cs_nxt  = r_arg;
            w_ce_nxt  = w_byte[6:0];
            w_col_nxt = r_arg;
          end else begin
            w_ps_nxt   = r_arg[2:0];
            w_pe_nxt   = w_byte[2:0];
            w_page_nxt = r_arg[2:0];
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign fb_we      = r_we;
  assign fb_addr    = r_addr;
  assign fb_data    = r_data;
  assign display_on = r_disp;
  assign invert     = r_inv;

endmodule

// File: tb/tb_ssd1306_cmd_decoder.sv
// Bench for ssd1306_cmd_decoder: serial byte driver, write scoreboard
// and per-feature scenario tasks.
module tb_ssd1306_cmd_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_dc = 1'b0;
  logic       fb_we;
  logic [9:0] fb_addr;
  logic [7:0] fb_data;
  logic       display_on;
  logic       invert;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];
  logic        prev_we = 1'b0;

  ssd1306_cmd_decoder #(
    .SYNC_STAGES(2), .COLS(128), .PAGES(8)
  ) dut (
    .CLK25MHz  (clk),
    .reset_n   (reset_n),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_cs_n  (spi_cs_n),
    .spi_dc    (spi_dc),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .display_on(display_on),
    .invert    (invert)
  );

  always #20 clk = ~clk;

  // Scoreboard: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h", fb_addr, fb_data);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if ({fb_addr, fb_data} !== e) begin
          errors++;
          $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                   fb_addr, fb_data, e[17:8], e[7:0]);
        end
      end
      checks++;
      if (prev_we) begin
        errors++;
        $display("FAIL we_width got 2+ cycles want 1");
      end
    end
    prev_we = fb_we;
  end

  task automatic spi_bits(input logic dc, input logic [7:0] b,
                          input int nbits);
    spi_dc = dc;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = b[i];
      repeat (4) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cmd(input logic [7:0] b);
    spi_bits(1'b0, b, 8);
  endtask

  task automatic data(input logic [7:0] b, input logic [9:0] addr);
    exp_q.push_back({addr, b});
    spi_bits(1'b1, b, 8);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending=%0d want 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    spi_dc   = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({fb_we, fb_addr, fb_data, display_on, invert} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {fb_we, fb_addr, fb_data, display_on, invert});
    end
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if ({fb_we, fb_addr, fb_data, display_on, invert} !== 21'd0) begin
      errors++;
      $display("FAIL post_reset_outputs got %h want 0",
               {fb_we, fb_addr, fb_data, display_on, invert});
    end
  endtask

  task automatic test_page_mode();
    do_reset();
    cmd(8'hB3); cmd(8'h05); cmd(8'h12);
    data(8'hA5, 10'd421);
    data(8'h5A, 10'd422);
    drain("page_mode");
  endtask

  task automatic test_horizontal();
    do_reset();
    cmd(8'h20); cmd(8'h00);
    cmd(8'h21); cmd(8'h7E); cmd(8'h7F);
    cmd(8'h22); cmd(8'h06); cmd(8'h07);
    data(8'h01, 10'd894);
    data(8'h02, 10'd895);
    data(8'h03, 10'd1022);
    data(8'h04, 10'd1023);
    data(8'h05, 10'd894);
    drain("horizontal");
  endtask

  task automatic test_vertical();
    do_reset();
    cmd(8'h20); cmd(8'h01);
    cmd(8'h21); cmd(8'h00); cmd(8'h01);
    cmd(8'h22); cmd(8'h00); cmd(8'h01);
    data(8'h11, 10'd0);
    data(8'h22, 10'd128);
    data(8'h33, 10'd1);
    data(8'h44, 10'd129);
    data(8'h55, 10'd0);
    drain("vertical");
  endtask

  task automatic test_flags();
    do_reset();
    cmd(8'hAF); cmd(8'hA7); cmd(8'h81); cmd(8'hAE);
    repeat (8) @(negedge clk);
    checks++;
    if (display_on !== 1'b1) begin
      errors++;
      $display("FAIL display_on_skip got %b want 1", display_on);
    end
    checks++;
    if (invert !== 1'b1) begin
      errors++;
      $display("FAIL invert_on got %b want 1", invert);
    end
    cmd(8'hAE); cmd(8'hA6);
    repeat (8) @(negedge clk);
    checks++;
    if (display_on !== 1'b0) begin
      errors++;
      $display("FAIL display_off got %b want 0", display_on);
    end
    checks++;
    if (invert !== 1'b0) begin
      errors++;
      $display("FAIL invert_off got %b want 0", invert);
    end
    drain("flags_no_write");
  endtask

  task automatic test_cs_abort();
    do_reset();
    cmd(8'hB1); cmd(8'h04); cmd(8'h10);
    spi_bits(1'b1, 8'hFF, 5);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    data(8'h3C, 10'd132);
    drain("cs_abort");
  endtask

  task automatic test_cmd_abort();
    do_reset();
    cmd(8'hB1); cmd(8'h04); cmd(8'h10);
    cmd(8'h21); cmd(8'h10);
    data(8'hFF, 10'd132);
    cmd(8'h20); cmd(8'h00);
    cmd(8'hB1); cmd(8'h0F); cmd(8'h17);
    data(8'hC1, 10'd255);
    data(8'hC2, 10'd256);
    drain("cmd_abort");
  endtask

  task automatic test_async_reset();
    do_reset();
    cmd(8'hAF); cmd(8'hA7); cmd(8'hB2);
    data(8'h5A, 10'd256);
    drain("pre_reset_write");
    spi_bits(1'b1, 8'hC3, 4);
    spi_mosi = 1'b1;
    spi_sclk = 1'b1;
    @(negedge clk);
    #5 reset_n = 1'b0;
    #1;
    checks++;
    if ({fb_we, fb_addr, fb_data, display_on, invert} !== 21'd0) begin
      errors++;
      $display("FAIL async_reset got %h want 0",
               {fb_we, fb_addr, fb_data, display_on, invert});
    end
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    data(8'h81, 10'd0);
    drain("post_reset_write");
  endtask

  initial begin
    test_reset();
    test_page_mode();
    test_horizontal();
    test_vertical();
    test_flags();
    test_cs_abort();
    test_cmd_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
